// File: rtl/axis_pkg.sv
// Shared helpers for the AXI-Stream merge/split blocks: parameter-derived
// widths that every module in this family computes the same way.
package axis_pkg;

    // Width of a select index for n streams; never narrower than one bit,
    // so a single-stream build still has a legal (constant-zero) register.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

    // tdata width in bits for a given byte count.
    function automatic int tdata_width(input int bytes);
        return bytes * 8;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice (main + skid). Every output port is
// driven from a flop, and the upstream ready is itself a flop, so this slice
// breaks both the forward and the backward timing paths while still moving
// one beat per clock when the downstream is always ready.
module axis_skid_buffer
    import axis_pkg::*;
#(
    parameter int AXIS_BYTES = 1
) (
    input  logic                               clk,
    input  logic                               sreset,
    output logic                               axis_i_tready,
    input  logic                               axis_i_tvalid,
    input  logic                               axis_i_tlast,
    input  logic [tdata_width(AXIS_BYTES)-1:0] axis_i_tdata,
    input  logic                               axis_o_tready,
    output logic                               axis_o_tvalid,
    output logic                               axis_o_tlast,
    output logic [tdata_width(AXIS_BYTES)-1:0] axis_o_tdata
);

    localparam int W = tdata_width(AXIS_BYTES);

    // Main entry: the beat currently presented downstream.
    logic         main_valid_q, main_valid_d;
    logic         main_last_q,  main_last_d;
    logic [W-1:0] main_data_q,  main_data_d;

    // Skid entry: catches the beat accepted while main was stalled.
    logic         skid_valid_q, skid_valid_d;
    logic         skid_last_q,  skid_last_d;
    logic [W-1:0] skid_data_q,  skid_data_d;

    // Registered "skid entry empty"; low throughout reset.
    logic         ready_q;

    logic         accept;
    logic         drain;

    assign accept = axis_i_tvalid && ready_q;
    assign drain  = main_valid_q && axis_o_tready;

    // Next-state for both entries: refill main from skid first, then from the
    // input; spill into skid only when main is occupied and not draining.
    always_comb begin
        // NOTE: every signal written here gets its hold value first, so no
        // path through the branches below can leave one unassigned (a latch).
        main_valid_d = main_valid_q;
        main_last_d  = main_last_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_last_d  = skid_last_q;
        skid_data_d  = skid_data_q;

        if (drain) begin
            if (skid_valid_q) begin
                // Skid full means ready_q is low, so no input beat competes.
                main_valid_d = 1'b1;
                main_last_d  = skid_last_q;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_last_d  = axis_i_tlast;
                main_data_d  = axis_i_tdata;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_last_d  = axis_i_tlast;
                main_data_d  = axis_i_tdata;
            end else begin
                skid_valid_d = 1'b1;
                skid_last_d  = axis_i_tlast;
                skid_data_d  = axis_i_tdata;
            end
        end
    end

    // Entry registers and the registered ready; reset drops any partial packet.
    always_ff @(posedge clk) begin
        if (sreset) begin
            // NOTE: the data registers are cleared too, because axis_o_tdata
            // is driven straight from main and must read zero out of reset.
            main_valid_q <= 1'b0;
            main_last_q  <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the
            // pre-edge values regardless of statement order.
            main_valid_q <= main_valid_d;
            main_last_q  <= main_last_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_last_q  <= skid_last_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= !skid_valid_d;
        end
    end

    assign axis_i_tready = ready_q;
    assign axis_o_tvalid = main_valid_q;
    assign axis_o_tlast  = main_last_q;
    assign axis_o_tdata  = main_data_q;

endmodule

// File: rtl/axis_round_robin_merge.sv
// Round-robin packet merge: takes one whole packet from each input stream in
// the fixed order 0,1,...,N-1,0,... and forwards it through a skid slice.
// This restores the original packet order after a round-robin splitter dealt
// packets out to parallel lanes. A selected stream that stays idle stalls the
// merge by design; skipping it would reorder packets.
module axis_round_robin_merge
    import axis_pkg::*;
#(
    parameter int AXIS_BYTES         = 1,
    parameter int NUM_MASTER_STREAMS = 1
) (
    input  logic                                                  clk,
    input  logic                                                  sreset,
    output logic [NUM_MASTER_STREAMS-1:0]                         axis_i_tready,
    input  logic [NUM_MASTER_STREAMS-1:0]                         axis_i_tvalid,
    input  logic [NUM_MASTER_STREAMS-1:0]                         axis_i_tlast,
    input  logic [NUM_MASTER_STREAMS*tdata_width(AXIS_BYTES)-1:0] axis_i_tdata,
    input  logic                                                  axis_o_tready,
    output logic                                                  axis_o_tvalid,
    output logic                                                  axis_o_tlast,
    output logic [tdata_width(AXIS_BYTES)-1:0]                    axis_o_tdata
);

    localparam int                     W        = tdata_width(AXIS_BYTES);
    localparam int                     SEL_BITS = clog2_min1(NUM_MASTER_STREAMS);
    localparam logic [SEL_BITS-1:0]    SEL_LAST = SEL_BITS'(NUM_MASTER_STREAMS - 1);

    // Index of the stream whose packet is currently being forwarded.
    logic [SEL_BITS-1:0] sel;

    logic                mux_tvalid;
    logic                mux_tlast;
    logic [W-1:0]        mux_tdata;
    logic                skid_ready;
    logic                beat_accepted;

    // Input mux: only the selected stream can reach the skid slice.
    always_comb begin
        mux_tvalid = 1'b0;
        mux_tlast  = 1'b0;
        mux_tdata  = '0;
        for (int k = 0; k < NUM_MASTER_STREAMS; k++) begin
            if (sel == SEL_BITS'(k)) begin
                mux_tvalid = axis_i_tvalid[k];
                mux_tlast  = axis_i_tlast[k];
                mux_tdata  = axis_i_tdata[k*W +: W];
            end
        end
    end

    // Ready decode: non-selected streams are held off and must keep their beat.
    always_comb begin
        axis_i_tready = '0;
        for (int k = 0; k < NUM_MASTER_STREAMS; k++) begin
            axis_i_tready[k] = (sel == SEL_BITS'(k)) && skid_ready;
        end
    end

    assign beat_accepted = mux_tvalid && skid_ready;

    // Advance to the next stream only after the last beat of a packet, so the
    // selection never moves mid-packet and the next stream can go immediately.
    always_ff @(posedge clk) begin
        if (sreset) begin
            sel <= '0;
        end else if (beat_accepted && mux_tlast) begin
            sel <= (sel == SEL_LAST) ? '0 : sel + SEL_BITS'(1);
        end
    end

    axis_skid_buffer #(
        .AXIS_BYTES (AXIS_BYTES)
    ) u_skid (
        .clk           (clk),
        .sreset        (sreset),
        .axis_i_tready (skid_ready),
        .axis_i_tvalid (mux_tvalid),
        .axis_i_tlast  (mux_tlast),
        .axis_i_tdata  (mux_tdata),
        .axis_o_tready (axis_o_tready),
        .axis_o_tvalid (axis_o_tvalid),
        .axis_o_tlast  (axis_o_tlast),
        .axis_o_tdata  (axis_o_tdata)
    );

endmodule

// File: tb/tb_axis_round_robin_merge.sv
// Bench for axis_round_robin_merge: a three-stream instance driven from
// per-stream source queues, plus a single-stream instance. Expected beats go
// into scoreboard queues when stimulus is issued; a negedge monitor pops and
// compares whenever the DUT transfers a beat.
`timescale 1ns/1ps
module tb_axis_round_robin_merge;

    localparam int N = 3;
    localparam int W = 8;

    typedef struct {
        int         cyc;
        logic       last;
        logic [7:0] data;
    } exp1_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           sreset;
    logic [N-1:0]   s_tready, s_tvalid, s_tlast;
    logic [N*W-1:0] s_tdata;
    logic           o_tready, o_tvalid, o_tlast;
    logic [W-1:0]   o_tdata;

    logic           n1_i_tready, n1_i_tvalid, n1_i_tlast;
    logic [W-1:0]   n1_i_tdata;
    logic           n1_o_tready, n1_o_tvalid, n1_o_tlast;
    logic [W-1:0]   n1_o_tdata;

    axis_round_robin_merge #(.AXIS_BYTES(1), .NUM_MASTER_STREAMS(N)) dut (
        .clk(clk), .sreset(sreset),
        .axis_i_tready(s_tready), .axis_i_tvalid(s_tvalid),
        .axis_i_tlast(s_tlast), .axis_i_tdata(s_tdata),
        .axis_o_tready(o_tready), .axis_o_tvalid(o_tvalid),
        .axis_o_tlast(o_tlast), .axis_o_tdata(o_tdata)
    );

    axis_round_robin_merge #(.AXIS_BYTES(1), .NUM_MASTER_STREAMS(1)) dut1 (
        .clk(clk), .sreset(sreset),
        .axis_i_tready(n1_i_tready), .axis_i_tvalid(n1_i_tvalid),
        .axis_i_tlast(n1_i_tlast), .axis_i_tdata(n1_i_tdata),
        .axis_o_tready(n1_o_tready), .axis_o_tvalid(n1_o_tvalid),
        .axis_o_tlast(n1_o_tlast), .axis_o_tdata(n1_o_tdata)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Source queues per stream and scoreboards; beats are {tlast, tdata}.
    logic [8:0] q0[$], q1[$], q2[$];
    logic [8:0] exp_q[$];
    exp1_t      exp1_q[$];
    int         out_cyc_q[$];
    logic [1:0] sel_log[$];

    logic [N-1:0] fire = '0;
    int           acc_cnt = 0, emit_cnt = 0, since_rst = 0, first_acc = -1;
    bit           log_en = 1'b0;
    logic         hold_prev = 1'b0;
    logic [8:0]   hold_beat;
    logic [8:0]   exp_beat;
    exp1_t        e1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: ready model, output stability, scoreboard pops for both DUTs.
    always @(negedge clk) begin
        if (sreset) begin
            fire      = '0;
            acc_cnt   = 0;
            emit_cnt  = 0;
            since_rst = 0;
            hold_prev = 1'b0;
        end else begin
            if (since_rst < 2) since_rst++;
            if (since_rst >= 2)
                check("ready_vs_occupancy", 32'(|s_tready), 32'((acc_cnt - emit_cnt) < 2));
            if (hold_prev) begin
                check("hold_valid", 32'(o_tvalid), 32'd1);
                check("hold_beat", 32'({o_tlast, o_tdata}), 32'(hold_beat));
            end
            fire = s_tvalid & s_tready;
            if (fire != '0) begin
                acc_cnt++;
                if (log_en) begin
                    sel_log.push_back(dut.sel);
                    if (first_acc < 0) first_acc = cyc;
                end
            end
            if (o_tvalid && o_tready) begin
                emit_cnt++;
                out_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_beat: got 0x%0h, none expected (cycle %0d)", {o_tlast, o_tdata}, cyc);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("out_beat", 32'({o_tlast, o_tdata}), 32'(exp_beat));
                end
            end
            hold_prev = o_tvalid && !o_tready;
            hold_beat = {o_tlast, o_tdata};

            if (n1_o_tvalid) begin
                if (exp1_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL n1_unexpected_beat: got 0x%0h, none expected", {n1_o_tlast, n1_o_tdata});
                end else begin
                    e1 = exp1_q.pop_front();
                    check("n1_beat", 32'({n1_o_tlast, n1_o_tdata}), 32'({e1.last, e1.data}));
                    check("n1_latency_cycle", 32'(cyc), 32'(e1.cyc));
                    check("n1_sel", 32'(dut1.sel), 32'd0);
                end
            end
        end
    end

    // Upstream sources: pop a beat the edge after it was accepted, then
    // present the head of each queue.
    initial begin
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (fire[0] && q0.size() > 0) void'(q0.pop_front());
            if (fire[1] && q1.size() > 0) void'(q1.pop_front());
            if (fire[2] && q2.size() > 0) void'(q2.pop_front());
            s_tvalid = {q2.size() > 0, q1.size() > 0, q0.size() > 0};
            s_tlast  = '0;
            s_tdata  = '0;
            if (q0.size() > 0) {s_tlast[0], s_tdata[0*W +: W]} = q0[0];
            if (q1.size() > 0) {s_tlast[1], s_tdata[1*W +: W]} = q1[0];
            if (q2.size() > 0) {s_tlast[2], s_tdata[2*W +: W]} = q2[0];
        end
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #3;
            n++;
        end
        check({"drain_", name}, 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #3;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [1:0] wrap_sel [4];
    logic [7:0] n1_data  [4];
    logic       n1_last  [4];
    int         base, n;

    initial begin
        wrap_sel = '{2'd0, 2'd1, 2'd2, 2'd0};
        n1_data  = '{8'hE0, 8'hE1, 8'hE2, 8'hF0};
        n1_last  = '{1'b0, 1'b0, 1'b1, 1'b1};
        sreset      = 1'b1;
        o_tready    = 1'b1;
        n1_o_tready = 1'b1;
        n1_i_tvalid = 1'b0;
        n1_i_tlast  = 1'b0;
        n1_i_tdata  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_o_tvalid", 32'(o_tvalid), 32'd0);
        check("rst_o_tlast", 32'(o_tlast), 32'd0);
        check("rst_o_tdata", 32'(o_tdata), 32'd0);
        check("rst_i_tready", 32'(s_tready), 32'd0);
        check("rst_n1_i_tready", 32'(n1_i_tready), 32'd0);
        check("rst_sel", 32'(dut.sel), 32'd0);
        @(posedge clk);
        #2 sreset = 1'b0;
        repeat (3) @(posedge clk);
        #3;

        // Ordering: all three packets presented together, zero-gap switching
        out_cyc_q.delete();
        first_acc = -1;
        log_en    = 1'b1;
        q0.push_back(9'h010); q0.push_back(9'h111);
        q1.push_back(9'h120);
        q2.push_back(9'h030); q2.push_back(9'h031); q2.push_back(9'h132);
        exp_q.push_back(9'h010); exp_q.push_back(9'h111); exp_q.push_back(9'h120);
        exp_q.push_back(9'h030); exp_q.push_back(9'h031); exp_q.push_back(9'h132);
        wait_drain("ordering");
        log_en = 1'b0;
        check("ord_beat_count", 32'(out_cyc_q.size()), 32'd6);
        if (out_cyc_q.size() >= 6) begin
            check("ord_first_out_cycle", 32'(out_cyc_q[0]), 32'(first_acc + 1));
            check("ord_last_out_cycle", 32'(out_cyc_q[5]), 32'(first_acc + 6));
        end
        check("ord_sel_end", 32'(dut.sel), 32'd0);

        // Blocking: stream 1 idle stalls the merge even though stream 2 is valid
        base = emit_cnt;
        q0.push_back(9'h140);
        q2.push_back(9'h160);
        exp_q.push_back(9'h140); exp_q.push_back(9'h155); exp_q.push_back(9'h160);
        repeat (12) @(posedge clk);
        #3;
        check("blk_outputs_before_s1", 32'(emit_cnt - base), 32'd1);
        check("blk_s2_valid", 32'(s_tvalid[2]), 32'd1);
        check("blk_s2_tready", 32'(s_tready[2]), 32'd0);
        check("blk_s1_tready", 32'(s_tready[1]), 32'd1);
        check("blk_sel", 32'(dut.sel), 32'd1);
        q1.push_back(9'h155);
        wait_drain("blocking");
        check("blk_sel_end", 32'(dut.sel), 32'd0);

        // Wrap: D waits behind A on stream 0 until C's tlast
        sel_log.delete();
        log_en = 1'b1;
        q0.push_back(9'h1A0); q0.push_back(9'h1D0);
        q1.push_back(9'h1B0);
        q2.push_back(9'h1C0);
        exp_q.push_back(9'h1A0); exp_q.push_back(9'h1B0);
        exp_q.push_back(9'h1C0); exp_q.push_back(9'h1D0);
        wait_drain("wrap");
        log_en = 1'b0;
        check("wrap_sel_count", 32'(sel_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < sel_log.size()) check("wrap_sel_seq", 32'(sel_log[i]), 32'(wrap_sel[i]));

        // Backpressure: output ready 1,0,0,1 during a 4-beat packet on stream 1
        q1.push_back(9'h001); q1.push_back(9'h002); q1.push_back(9'h003); q1.push_back(9'h104);
        exp_q.push_back(9'h001); exp_q.push_back(9'h002);
        exp_q.push_back(9'h003); exp_q.push_back(9'h104);
        @(posedge clk); #1 o_tready = 1'b1;
        @(posedge clk); #1 o_tready = 1'b0;
        @(posedge clk); #1 o_tready = 1'b0;
        @(posedge clk); #1 o_tready = 1'b1;
        wait_drain("backpressure");

        // Single beat on stream 2 brings the selection back to stream 0
        q2.push_back(9'h170);
        exp_q.push_back(9'h170);
        wait_drain("filler");
        check("pre_rst_sel", 32'(dut.sel), 32'd0);

        // Reset mid-packet: two beats stuck in the slice are discarded
        o_tready = 1'b0;
        q0.push_back(9'h081); q0.push_back(9'h082); q0.push_back(9'h083); q0.push_back(9'h184);
        n = 0;
        while ((acc_cnt - emit_cnt) != 2 && n < 20) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("rst_mid_fill", 32'(acc_cnt - emit_cnt), 32'd2);
        check("rst_mid_tready_full", 32'(s_tready[0]), 32'd0);
        @(posedge clk);
        #2 sreset = 1'b1;
        q0.delete(); q1.delete(); q2.delete();
        @(posedge clk);
        #2 sreset = 1'b0;
        o_tready = 1'b1;
        @(negedge clk);
        check("rst_mid_o_tvalid", 32'(o_tvalid), 32'd0);
        check("rst_mid_sel", 32'(dut.sel), 32'd0);
        repeat (4) @(posedge clk);
        #3;
        check("rst_mid_no_stale", 32'(emit_cnt), 32'd0);
        q0.push_back(9'h091); q0.push_back(9'h192);
        exp_q.push_back(9'h091); exp_q.push_back(9'h192);
        wait_drain("after_reset");

        // Single-stream build: back-to-back beats, one-cycle latency
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            n1_i_tvalid = 1'b1;
            n1_i_tdata  = n1_data[i];
            n1_i_tlast  = n1_last[i];
            @(negedge clk);
            check("n1_tready", 32'(n1_i_tready), 32'd1);
            if (n1_i_tready) exp1_q.push_back('{cyc + 1, n1_last[i], n1_data[i]});
        end
        @(posedge clk);
        #1 n1_i_tvalid = 1'b0;
        n = 0;
        while (exp1_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("n1_drain", 32'(exp1_q.size()), 32'd0);
        check("n1_sel_end", 32'(dut1.sel), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
